// File: rtl/dff_serial_capture_if.sv
// Bundle between the flip-flop stage and the serial capture block:
// sampled Q/nQ pair and acknowledge in, captured word and status out.
interface dff_serial_capture_if #(
  parameter int WIDTH = 8
);
  logic             Q;
  logic             nQ;
  logic             A;
  logic [WIDTH-1:0] P;
  logic             V;
  logic             E;
  logic             O;
  logic             B;

  modport master (
    output Q, nQ, A,
    input  P, V, E, O, B
  );

  modport slave (
    input  Q, nQ, A,
    output P, V, E, O, B
  );
endinterface

// File: rtl/dff_serial_capture.sv
// Deserialises a start/data/stop framed stream from a complementary Q/nQ
// flip-flop pair into a parallel word with a valid/acknowledge handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a start bit (Q=1, nQ=0)
// S_SHIFT | collecting WIDTH data bits, checking Q/nQ complement
// S_STOP  | checking the stop bit (Q=0, nQ=1) and loading the word
module dff_serial_capture #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                C,
  input  logic                R,
  dff_serial_capture_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
    $error("dff_serial_capture: WIDTH must be in 1..32");
  end

  // One spare bit so the counter can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_STOP  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] word;
  logic             valid;
  logic             err;
  logic             overrun;
  logic             busy;

  logic             comp_ok;
  logic             start_bit;
  logic             stop_good;
  logic             load;

  assign comp_ok   = bus.Q ^ bus.nQ;
  assign start_bit = bus.Q & ~bus.nQ;
  assign stop_good = ~bus.Q & bus.nQ;
  assign load      = (state == S_STOP) && stop_good;

  // LSB-first shifts in at the top so the first bit ends in bit 0.
  if (WIDTH == 1) begin : g_shift_one
    assign shift_next = bus.Q;
  end else if (LSB_FIRST) begin : g_shift_lsb
    assign shift_next = {bus.Q, shift_reg[WIDTH-1:1]};
  end else begin : g_shift_msb
    assign shift_next = {shift_reg[WIDTH-2:0], bus.Q};
  end

  always_ff @(posedge C) begin
    if (R) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      word      <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_bit) begin
            state   <= S_SHIFT;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (!comp_ok) begin
            err       <= 1'b1;
            state     <= S_IDLE;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= S_STOP;
            end
          end
        end

        S_STOP: begin
          // Wrong stop level and a complement fault both flag an error.
          if (!stop_good) begin
            err <= 1'b1;
          end
          state   <= S_IDLE;
          busy    <= 1'b0;
          bit_cnt <= '0;
        end

        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase

      if (load) begin
        word  <= shift_reg;
        valid <= 1'b1;
        if (valid && !bus.A) begin
          overrun <= 1'b1;
        end
      end else if (valid && bus.A) begin
        valid <= 1'b0;
      end
    end
  end

  assign bus.P = word;
  assign bus.V = valid;
  assign bus.E = err;
  assign bus.O = overrun;
  assign bus.B = busy;

endmodule
